// File: rtl/wb_bram_arbiter.sv
// wb_bram_arbiter: two-master Wishbone arbiter sharing one BRAM slave, with a turnaround cycle between owners.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise m0 always wins ties.
module wb_bram_arbiter #(
    parameter int ADR_W = 32,
    parameter int DAT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m0_cyc,
    input  logic               m0_stb,
    input  logic               m0_we,
    input  logic [ADR_W-1:0]   m0_adr,
    input  logic [DAT_W-1:0]   m0_dat_ms,
    input  logic [DAT_W/8-1:0] m0_sel,
    output logic [DAT_W-1:0]   m0_dat_sm,
    output logic               m0_ack,
    output logic               m0_err,
    output logic               m0_rty,
    input  logic               m1_cyc,
    input  logic               m1_stb,
    input  logic               m1_we,
    input  logic [ADR_W-1:0]   m1_adr,
    input  logic [DAT_W-1:0]   m1_dat_ms,
    input  logic [DAT_W/8-1:0] m1_sel,
    output logic [DAT_W-1:0]   m1_dat_sm,
    output logic               m1_ack,
    output logic               m1_err,
    output logic               m1_rty,
    output logic               s_cyc,
    output logic               s_stb,
    output logic               s_we,
    output logic [ADR_W-1:0]   s_adr,
    output logic [DAT_W-1:0]   s_dat_ms,
    output logic [DAT_W/8-1:0] s_sel,
    input  logic [DAT_W-1:0]   s_dat_sm,
    input  logic               s_ack,
    input  logic               s_err,
    input  logic               s_rty
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1, TURN} state_t;
    state_t r_state;
    logic w_pick1;
    logic w_g0;
    logic w_g1;
`ifdef WB_ARB_ROUND_ROBIN_EN
    logic r_last_owner;
    assign w_pick1 = m1_cyc & (~m0_cyc | ~r_last_owner);
    always_ff @(posedge clk) begin
        if (rst)
            r_last_owner <= 1'b1;
        else if (r_state == IDLE && (m0_cyc || m1_cyc))
            r_last_owner <= w_pick1;
    end
`else
    assign w_pick1 = m1_cyc & ~m0_cyc;
`endif
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            case (r_state)
                IDLE:    if (m0_cyc || m1_cyc) r_state <= w_pick1 ? GNT1 : GNT0;
                GNT0:    if (!m0_cyc) r_state <= TURN;
                GNT1:    if (!m1_cyc) r_state <= TURN;
                default: r_state <= IDLE;
            endcase
    end
    assign w_g0 = r_state == GNT0;
    assign w_g1 = r_state == GNT1;
    always_comb begin
        s_cyc    = w_g0 ? m0_cyc    : w_g1 ? m1_cyc    : 1'b0;
        s_stb    = w_g0 ? m0_stb    : w_g1 ? m1_stb    : 1'b0;
        s_we     = w_g0 ? m0_we     : w_g1 ? m1_we     : 1'b0;
        s_adr    = w_g0 ? m0_adr    : w_g1 ? m1_adr    : '0;
        s_dat_ms = w_g0 ? m0_dat_ms : w_g1 ? m1_dat_ms : '0;
        s_sel    = w_g0 ? m0_sel    : w_g1 ? m1_sel    : '0;
    end
    // Gating by the master's own cyc drops a late read ack after that master has let go.
    assign m0_ack    = s_ack & w_g0 & m0_cyc;
    assign m0_err    = s_err & w_g0 & m0_cyc;
    assign m0_rty    = s_rty & w_g0 & m0_cyc;
    assign m1_ack    = s_ack & w_g1 & m1_cyc;
    assign m1_err    = s_err & w_g1 & m1_cyc;
    assign m1_rty    = s_rty & w_g1 & m1_cyc;
    assign m0_dat_sm = s_dat_sm;
    assign m1_dat_sm = s_dat_sm;
endmodule

// File: tb/tb_wb_bram_arbiter.sv
// tb_wb_bram_arbiter: vector table, directed BRAM sequences and random traffic against an ownership model.
module tb_wb_bram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
`ifdef WB_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic        t_cyc [2];
    logic        t_stb [2];
    logic        t_we  [2];
    logic [31:0] t_adr [2];
    logic [31:0] t_dat [2];
    logic [3:0]  t_sel [2];
    logic [31:0] m0_dat_sm, m1_dat_sm, s_adr, s_dat_ms, s_dat_sm;
    logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
    logic        s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
    logic [3:0]  s_sel;
    logic        use_ram = 1'b0;
    logic        mem_init = 1'b1;
    logic        r_rd = 1'b0;
    logic [31:0] r_rdat = '0;
    logic [31:0] mem [256];
    logic        rnd_ack = 1'b0, rnd_err = 1'b0, rnd_rty = 1'b0;
    logic [31:0] rnd_dat = '0;
    int checks = 0;
    int failures = 0;
    int m_owner = -1;
    int m_cool = 0;
    bit m_last = 1'b1;

    wb_bram_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_cyc(t_cyc[0]), .m0_stb(t_stb[0]), .m0_we(t_we[0]), .m0_adr(t_adr[0]),
        .m0_dat_ms(t_dat[0]), .m0_sel(t_sel[0]), .m0_dat_sm(m0_dat_sm),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty),
        .m1_cyc(t_cyc[1]), .m1_stb(t_stb[1]), .m1_we(t_we[1]), .m1_adr(t_adr[1]),
        .m1_dat_ms(t_dat[1]), .m1_sel(t_sel[1]), .m1_dat_sm(m1_dat_sm),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_dat_sm(s_dat_sm),
        .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty)
    );

    // BRAM model: write ack in the strobe cycle, pipelined read ack one cycle later
    assign s_ack    = use_ram ? ((s_cyc & s_stb & s_we) | r_rd) : rnd_ack;
    assign s_err    = use_ram ? 1'b0 : rnd_err;
    assign s_rty    = use_ram ? 1'b0 : rnd_rty;
    assign s_dat_sm = use_ram ? r_rdat : rnd_dat;
    always @(posedge clk) begin
        r_rd   <= use_ram & s_cyc & s_stb & ~s_we;
        r_rdat <= mem[s_adr[9:2]];
        if (mem_init)
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + i;
        else if (use_ram && s_cyc && s_stb && s_we)
            for (int b = 0; b < 4; b++) if (s_sel[b]) mem[s_adr[9:2]][8*b +: 8] <= s_dat_ms[8*b +: 8];
    end

    // Ownership model: one owner at a time, then one release cycle before arbitration resumes
    function automatic int winner();
        if (t_cyc[0] && t_cyc[1]) return (RR && !m_last) ? 1 : 0;
        return t_cyc[0] ? 0 : 1;
    endfunction
    always @(posedge clk) begin
        if (rst) begin
            m_owner <= -1;
            m_cool  <= 0;
            m_last  <= 1'b1;
        end else if (m_owner >= 0) begin
            if (!t_cyc[m_owner]) begin
                m_owner <= -1;
                m_cool  <= 1;
            end
        end else if (m_cool > 0) begin
            m_cool <= m_cool - 1;
        end else if (t_cyc[0] || t_cyc[1]) begin
            m_owner <= winner();
            m_last  <= winner() == 1;
        end
    end

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic check_all();
        logic [70:0] es;
        es = m_owner == 0 ? {t_cyc[0], t_stb[0], t_we[0], t_adr[0], t_dat[0], t_sel[0]} :
             m_owner == 1 ? {t_cyc[1], t_stb[1], t_we[1], t_adr[1], t_dat[1], t_sel[1]} : '0;
        chk("slave_bus", 128'({s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel}), 128'(es));
        chk("m0_resp", 128'({m0_ack, m0_err, m0_rty, m0_dat_sm}),
            128'({s_ack && m_owner == 0 && t_cyc[0], s_err && m_owner == 0 && t_cyc[0],
                  s_rty && m_owner == 0 && t_cyc[0], s_dat_sm}));
        chk("m1_resp", 128'({m1_ack, m1_err, m1_rty, m1_dat_sm}),
            128'({s_ack && m_owner == 1 && t_cyc[1], s_err && m_owner == 1 && t_cyc[1],
                  s_rty && m_owner == 1 && t_cyc[1], s_dat_sm}));
    endtask

    task automatic idle_masters();
        for (int i = 0; i < 2; i++) begin
            t_cyc[i] = 1'b0; t_stb[i] = 1'b0; t_we[i] = 1'b0;
            t_adr[i] = '0;   t_dat[i] = '0;   t_sel[i] = '0;
        end
    endtask

    typedef struct packed {
        logic rst, c0, s0, c1, s1, ack;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl [15];

    initial begin
        int order[$];
        int exp_order[4];
        int bursts[2], cnt[2], drop_t[2];
        int last_drop, prev_own, own, fin;
        idle_masters();
        // {rst, m0 cyc, m0 stb, m1 cyc, m1 stb, s_ack} -> {s_cyc, s_stb, m0_ack, m1_ack}
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 4'b0000};
        tbl[1]  = '{0, 1, 1, 1, 1, 1, 4'b1110};
        tbl[2]  = '{0, 1, 1, 1, 1, 1, 4'b1110};
        tbl[3]  = '{0, 0, 0, 1, 1, 1, 4'b0000};
        tbl[4]  = '{0, 0, 0, 1, 1, 1, 4'b0000};
        tbl[5]  = '{0, 0, 0, 1, 1, 1, 4'b1101};
        tbl[6]  = '{0, 0, 0, 0, 0, 1, 4'b0000};
        tbl[7]  = '{0, 0, 0, 1, 1, 0, 4'b0000};
        tbl[8]  = '{0, 0, 0, 1, 1, 1, 4'b1101};
        tbl[9]  = '{1, 0, 0, 1, 1, 1, 4'b0000};
        tbl[10] = '{0, 0, 0, 1, 1, 1, 4'b1101};
        tbl[11] = '{0, 0, 0, 1, 0, 0, 4'b1000};
        tbl[12] = '{0, 0, 0, 0, 0, 1, 4'b0000};
        tbl[13] = '{0, 1, 1, 0, 0, 1, 4'b0000};
        tbl[14] = '{0, 1, 1, 0, 0, 1, 4'b1110};
        t_adr[0] = 32'h100; t_adr[1] = 32'h200;
        @(negedge clk);
        mem_init = 1'b0;
        for (int v = 0; v < 15; v++) begin
            rst = tbl[v].rst; t_cyc[0] = tbl[v].c0; t_stb[0] = tbl[v].s0;
            t_cyc[1] = tbl[v].c1; t_stb[1] = tbl[v].s1; rnd_ack = tbl[v].ack;
            @(negedge clk);
            chk($sformatf("vec%0d", v), 128'({s_cyc, s_stb, m0_ack, m1_ack}), 128'(tbl[v].exp));
        end

        // Reset, then ten quiet cycles
        idle_masters();
        use_ram = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_all();
            chk("quiet", 128'({s_cyc, s_stb, m0_ack, m1_ack}), 128'(0));
        end

        // m1 writes 0xDEADBEEF to 0x10, then m0 reads it back after the gap
        t_cyc[1] = 1'b1; t_stb[1] = 1'b1; t_we[1] = 1'b1;
        t_adr[1] = 32'h10; t_dat[1] = 32'hDEAD_BEEF; t_sel[1] = 4'hF;
        @(negedge clk);
        check_all();
        chk("m1_wr_ack", 128'(m1_ack), 128'(1));
        @(negedge clk);
        check_all();
        t_cyc[1] = 1'b0; t_stb[1] = 1'b0; t_we[1] = 1'b0;
        t_cyc[0] = 1'b1; t_stb[0] = 1'b1; t_we[0] = 1'b0; t_adr[0] = 32'h10;
        repeat (2) begin
            @(negedge clk);
            check_all();
            chk("gap_idle", 128'({s_cyc, m0_ack}), 128'(0));
        end
        @(negedge clk);
        check_all();
        chk("m0_rd_stb", 128'({s_stb, m0_ack}), 128'(2'b10));
        @(negedge clk);
        check_all();
        chk("m0_rd_data", 128'({m0_ack, m0_dat_sm}), 128'({1'b1, 32'hDEAD_BEEF}));
        idle_masters();

        // Simultaneous 4-beat read bursts, two per master; final ack cycle keeps stb, cyc drops after the edge
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            t_cyc[i] = 1'b1; t_stb[i] = 1'b1; t_we[i] = 1'b0;
            t_adr[i] = (i + 1) * 32'h100;
            bursts[i] = 0; cnt[i] = 0; drop_t[i] = -10;
        end
        last_drop = -3;
        prev_own = -1;
        for (int t = 0; t < 100 && (bursts[0] < 2 || bursts[1] < 2); t++) begin
            @(negedge clk);
            check_all();
            own = !s_cyc ? -1 : (s_adr[9:8] == 2'd1 ? 0 : 1);
            if (own >= 0 && own != prev_own) begin
                order.push_back(own);
                chk("grant_gap", 128'(t), 128'(last_drop + 3));
            end
            prev_own = own;
            if (!s_cyc) chk("ack_unowned", 128'({m0_ack, m1_ack}), 128'(0));
            if (own == 0) chk("m1_stall", 128'(m1_ack), 128'(0));
            if (own == 1) chk("m0_stall", 128'(m0_ack), 128'(0));
            fin = -1;
            for (int i = 0; i < 2; i++) begin
                if (!t_cyc[i] && bursts[i] < 2 && t == drop_t[i] + 1) begin
                    t_cyc[i] = 1'b1; t_stb[i] = 1'b1;
                end
                if (i == 0 ? m0_ack : m1_ack) begin
                    chk($sformatf("rdata_m%0d", i), 128'(i == 0 ? m0_dat_sm : m1_dat_sm),
                        128'(32'hA000_0000 + t_adr[i][9:2]));
                    t_adr[i] += 4;
                    cnt[i]++;
                    if (cnt[i] == 4) fin = i;
                end
            end
            if (fin >= 0) begin
                @(posedge clk);
                #1;
                t_cyc[fin] = 1'b0; t_stb[fin] = 1'b0;
                cnt[fin] = 0; bursts[fin]++;
                drop_t[fin] = t + 1; last_drop = t + 1;
            end
        end
        chk("bursts_done", 128'({bursts[0], bursts[1]}), 128'({32'd2, 32'd2}));
        exp_order = RR ? '{0, 1, 0, 1} : '{0, 0, 1, 1};
        chk("grant_count", 128'(order.size()), 128'(4));
        for (int k = 0; k < 4 && k < order.size(); k++)
            chk($sformatf("grant_order%0d", k), 128'(order[k]), 128'(exp_order[k]));
        idle_masters();
        repeat (3) @(negedge clk);

        // Reset pulse during an m1 read with stb high
        t_cyc[1] = 1'b1; t_stb[1] = 1'b1; t_we[1] = 1'b0; t_adr[1] = 32'h204;
        @(negedge clk);
        check_all();
        chk("rst_pre_stb", 128'(s_stb), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        check_all();
        chk("rst_quiet", 128'({s_cyc, s_stb, m1_ack}), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        check_all();
        chk("rst_regrant", 128'({s_stb, m1_ack}), 128'(2'b10));
        @(negedge clk);
        check_all();
        chk("rst_rd_data", 128'({m1_ack, m1_dat_sm}), 128'({1'b1, 32'hA000_0081}));
        idle_masters();
        use_ram = 1'b0;

        // Random traffic against the ownership model
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            check_all();
            rst = $urandom_range(0, 199) == 0;
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 7) == 0) t_cyc[i] = ~t_cyc[i];
                t_stb[i] = 1'($urandom);
                t_we[i]  = 1'($urandom);
                t_adr[i] = $urandom;
                t_dat[i] = $urandom;
                t_sel[i] = 4'($urandom);
            end
            rnd_ack = 1'($urandom);
            rnd_err = $urandom_range(0, 3) == 0;
            rnd_rty = $urandom_range(0, 3) == 0;
            rnd_dat = $urandom;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
